// File: rtl/midi_parameter_controller_pkg.sv
// Shared MIDI constants, parser state encoding and the synth parameter types.
// Optional feature macro: MIDI_RESET_ALL_CONTROLLERS_EN (CC 121 restores default parameters).
package midi_parameter_controller_pkg;

    localparam logic [3:0] STATUS_CC      = 4'hB;
    localparam logic [3:0] STATUS_PROGRAM = 4'hC;
    localparam logic [7:0] REALTIME_MIN   = 8'hF8;

    localparam logic [6:0] CC_VOLUME        = 7'd7;
    localparam logic [6:0] CC_UNISON_DETUNE = 7'd94;
    localparam logic [6:0] CC_ATTACK_TIME   = 7'd73;
    localparam logic [6:0] CC_DECAY_TIME    = 7'd75;
    localparam logic [6:0] CC_SUSTAIN_LEVEL = 7'd79;
    localparam logic [6:0] CC_RELEASE_TIME  = 7'd72;
    localparam logic [6:0] CC_DUTY_CYCLE    = 7'd70;
`ifdef MIDI_RESET_ALL_CONTROLLERS_EN
    localparam logic [6:0] CC_RESET_ALL     = 7'd121;
`endif

    typedef enum logic [2:0] {
        ST_IDLE, ST_DATA1, ST_DATA2, ST_APPLY, ST_SKIP
    } parser_state_t;

    typedef struct packed {
        logic [6:0] volume;
        logic [6:0] unison_detune;
        logic [6:0] attack_time;
        logic [6:0] decay_time;
        logic [6:0] sustain_level;
        logic [6:0] release_time;
        logic [6:0] duty_cycle;
    } parameter_t;

    localparam parameter_t DEFAULT_PARAMETERS = '{
        volume:        7'h40,
        unison_detune: 7'h00,
        attack_time:   7'h00,
        decay_time:    7'h00,
        sustain_level: 7'h7F,
        release_time:  7'h00,
        duty_cycle:    7'h40
    };

    typedef enum logic [2:0] {
        SINE = 3'd0, SQUARE = 3'd1, SAW = 3'd2, TRIANGLE = 3'd3,
        PULSE = 3'd4, VIOLA = 3'd5, ORGAN = 3'd6, NOISE = 3'd7
    } wave_t;

    typedef enum logic [3:0] {
        PARAM_NONE          = 4'd0,
        PARAM_VOLUME        = 4'd1,
        PARAM_UNISON_DETUNE = 4'd2,
        PARAM_ATTACK_TIME   = 4'd3,
        PARAM_DECAY_TIME    = 4'd4,
        PARAM_SUSTAIN_LEVEL = 4'd5,
        PARAM_RELEASE_TIME  = 4'd6,
        PARAM_DUTY_CYCLE    = 4'd7
`ifdef MIDI_RESET_ALL_CONTROLLERS_EN
        , PARAM_RESET_ALL   = 4'd8
`endif
    } parameter_change_t;

    function automatic logic channel_ok(input logic [3:0] ch, input logic [3:0] listen,
                                        input bit omni);
        return omni || (ch == listen);
    endfunction

endpackage

// File: rtl/midi_parameter_controller_midi_byte_parser.sv
// MIDI byte-stream parser: tracks running status for CC / Program Change on the
// listened channel and strobes a complete message for one cycle in APPLY.
module midi_byte_parser
    import midi_parameter_controller_pkg::*;
#(
    parameter logic [3:0] LISTEN_CHANNEL = 4'd0,
    parameter bit         OMNI           = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] i_byte,
    input  logic       i_valid,
    output logic       o_ready,
    output logic       o_msg_valid,
    output logic [3:0] o_status,
    output logic [6:0] o_d1,
    output logic [6:0] o_d2
);

    parser_state_t r_state, w_state_next;
    logic [3:0]    r_status, w_status_next;
    logic [6:0]    r_d1, w_d1_next;
    logic [6:0]    r_d2, w_d2_next;

    logic w_accept;
    logic w_is_realtime;
    logic w_wanted;

    assign o_ready       = (r_state != ST_APPLY);
    assign w_accept      = i_valid && o_ready;
    assign w_is_realtime = (i_byte >= REALTIME_MIN);
    assign w_wanted      = ((i_byte[7:4] == STATUS_CC) || (i_byte[7:4] == STATUS_PROGRAM))
                           && channel_ok(i_byte[3:0], LISTEN_CHANNEL, OMNI);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_status <= '0;
            r_d1     <= '0;
            r_d2     <= '0;
        end else begin
            r_state  <= w_state_next;
            r_status <= w_status_next;
            r_d1     <= w_d1_next;
            r_d2     <= w_d2_next;
        end
    end

    // Real-time bytes are consumed but never touch the decoder state.
    always_comb begin
        w_state_next  = r_state;
        w_status_next = r_status;
        w_d1_next     = r_d1;
        w_d2_next     = r_d2;
        if (r_state == ST_APPLY) begin
            w_state_next = ST_DATA1;
        end else if (w_accept && !w_is_realtime) begin
            if (i_byte[7]) begin
                if (w_wanted) begin
                    w_state_next  = ST_DATA1;
                    w_status_next = i_byte[7:4];
                end else begin
                    w_state_next  = ST_SKIP;
                    w_status_next = '0;
                end
            end else begin
                case (r_state)
                    ST_DATA1: begin
                        w_d1_next    = i_byte[6:0];
                        w_state_next = (r_status == STATUS_PROGRAM) ? ST_APPLY : ST_DATA2;
                    end
                    ST_DATA2: begin
                        w_d2_next    = i_byte[6:0];
                        w_state_next = ST_APPLY;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_msg_valid = (r_state == ST_APPLY);
    assign o_status    = r_status;
    assign o_d1        = r_d1;
    assign o_d2        = r_d2;

endmodule

// File: rtl/midi_parameter_controller.sv
// MIDI parameter controller top: maps parsed CC / Program Change messages onto the
// live parameter set and waveform. Optional macro: MIDI_RESET_ALL_CONTROLLERS_EN.
module midi_parameter_controller
    import midi_parameter_controller_pkg::*;
#(
    parameter logic [3:0] LISTEN_CHANNEL = 4'd0,
    parameter bit         OMNI           = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        midi_byte,
    input  logic              midi_valid,
    output logic              midi_ready,
    output parameter_t        parameters,
    output wave_t             wave,
    output parameter_change_t param_change,
    output logic              wave_change
);

    logic       w_msg_valid;
    logic [3:0] w_status;
    logic [6:0] w_d1;
    logic [6:0] w_d2;

    parameter_t        r_parameters, w_parameters_next;
    wave_t             r_wave;
    parameter_change_t r_param_change, w_change;
    logic              r_wave_change;
    logic              w_is_program;

    midi_byte_parser #(
        .LISTEN_CHANNEL(LISTEN_CHANNEL),
        .OMNI          (OMNI)
    ) u_parser (
        .clk        (clk),
        .rst        (rst),
        .i_byte     (midi_byte),
        .i_valid    (midi_valid),
        .o_ready    (midi_ready),
        .o_msg_valid(w_msg_valid),
        .o_status   (w_status),
        .o_d1       (w_d1),
        .o_d2       (w_d2)
    );

    assign w_is_program = w_msg_valid && (w_status == STATUS_PROGRAM);

    // Unmapped controllers fall through with no write and no change tag.
    always_comb begin
        w_parameters_next = r_parameters;
        w_change          = PARAM_NONE;
        if (w_msg_valid && (w_status == STATUS_CC)) begin
            case (w_d1)
                CC_VOLUME:        begin w_parameters_next.volume        = w_d2; w_change = PARAM_VOLUME;        end
                CC_UNISON_DETUNE: begin w_parameters_next.unison_detune = w_d2; w_change = PARAM_UNISON_DETUNE; end
                CC_ATTACK_TIME:   begin w_parameters_next.attack_time   = w_d2; w_change = PARAM_ATTACK_TIME;   end
                CC_DECAY_TIME:    begin w_parameters_next.decay_time    = w_d2; w_change = PARAM_DECAY_TIME;    end
                CC_SUSTAIN_LEVEL: begin w_parameters_next.sustain_level = w_d2; w_change = PARAM_SUSTAIN_LEVEL; end
                CC_RELEASE_TIME:  begin w_parameters_next.release_time  = w_d2; w_change = PARAM_RELEASE_TIME;  end
                CC_DUTY_CYCLE:    begin w_parameters_next.duty_cycle    = w_d2; w_change = PARAM_DUTY_CYCLE;    end
`ifdef MIDI_RESET_ALL_CONTROLLERS_EN
                CC_RESET_ALL:     begin w_parameters_next = DEFAULT_PARAMETERS; w_change = PARAM_RESET_ALL;     end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_parameters   <= DEFAULT_PARAMETERS;
            r_wave         <= SINE;
            r_param_change <= PARAM_NONE;
            r_wave_change  <= 1'b0;
        end else begin
            r_parameters   <= w_parameters_next;
            r_param_change <= w_change;
            r_wave_change  <= w_is_program;
            if (w_is_program) begin
                r_wave <= wave_t'(w_d1[2:0]);
            end
        end
    end

    assign parameters   = r_parameters;
    assign wave         = r_wave;
    assign param_change = r_param_change;
    assign wave_change  = r_wave_change;

endmodule

// File: tb/tb_midi_parameter_controller.sv
// Self-checking bench: directed MIDI sequences plus random byte streams, compared
// against a message-level reference model (running status + data queue).
`timescale 1ns/1ps
module tb_midi_parameter_controller;
    import midi_parameter_controller_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic [7:0]        midi_byte;
    logic              midi_valid;
    logic              midi_ready;
    parameter_t        parameters;
    wave_t             wave;
    parameter_change_t param_change;
    logic              wave_change;

    always #5 clk = ~clk;

    midi_parameter_controller dut (
        .clk         (clk),
        .rst         (rst),
        .midi_byte   (midi_byte),
        .midi_valid  (midi_valid),
        .midi_ready  (midi_ready),
        .parameters  (parameters),
        .wave        (wave),
        .param_change(param_change),
        .wave_change (wave_change)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [7:0] m_rs;
    logic [6:0] m_q[$];
    parameter_t m_par;
    logic [2:0] m_wave;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic parameter_t model_defaults();
        parameter_t p;
        p = '0;
        p.volume        = 7'h40;
        p.sustain_level = 7'h7F;
        p.duty_cycle    = 7'h40;
        return p;
    endfunction

    task automatic model_reset();
        m_rs = 8'h00;
        m_q.delete();
        m_par = model_defaults();
        m_wave = 3'd0;
    endtask

    task automatic model_byte(input logic [7:0] b, output bit done,
                              output parameter_change_t tag, output bit wc);
        int need;
        done = 0;
        tag  = PARAM_NONE;
        wc   = 0;
        if (b >= 8'hF8) return;
        if (b[7]) begin
            m_q.delete();
            if ((b[7:4] == 4'hB || b[7:4] == 4'hC) && b[3:0] == 4'd0) m_rs = b;
            else m_rs = 8'h00;
            return;
        end
        if (m_rs == 8'h00) return;
        m_q.push_back(b[6:0]);
        need = (m_rs[7:4] == 4'hC) ? 1 : 2;
        if (m_q.size() < need) return;
        done = 1;
        if (m_rs[7:4] == 4'hC) begin
            m_wave = m_q[0][2:0];
            wc = 1;
        end else begin
            case (int'(m_q[0]))
                7:  begin m_par.volume        = m_q[1]; tag = PARAM_VOLUME;        end
                94: begin m_par.unison_detune = m_q[1]; tag = PARAM_UNISON_DETUNE; end
                73: begin m_par.attack_time   = m_q[1]; tag = PARAM_ATTACK_TIME;   end
                75: begin m_par.decay_time    = m_q[1]; tag = PARAM_DECAY_TIME;    end
                79: begin m_par.sustain_level = m_q[1]; tag = PARAM_SUSTAIN_LEVEL; end
                72: begin m_par.release_time  = m_q[1]; tag = PARAM_RELEASE_TIME;  end
                70: begin m_par.duty_cycle    = m_q[1]; tag = PARAM_DUTY_CYCLE;    end
`ifdef MIDI_RESET_ALL_CONTROLLERS_EN
                121: begin m_par = model_defaults(); tag = PARAM_RESET_ALL; end
`endif
                default: ;
            endcase
        end
        m_q.delete();
    endtask

    // One byte handshake; checks ready, the one-cycle pulse and the registered state.
    task automatic send(input logic [7:0] b);
        bit done, wc;
        parameter_change_t tag;
        int guard;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        midi_byte  = b;
        midi_valid = 1'b1;
        guard = 0;
        while (!midi_ready && guard < 10) begin @(posedge clk); #1; guard++; end
        check("ready_before", midi_ready, 1'b1);
        @(posedge clk); #1;
        midi_valid = 1'b0;
        model_byte(b, done, tag, wc);
        check("pulse_clear", {param_change, wave_change}, {PARAM_NONE, 1'b0});
        check("ready_apply", midi_ready, !done);
        @(posedge clk); #1;
        check("param_change", param_change, tag);
        check("wave_change", wave_change, wc);
        check("parameters", parameters, m_par);
        check("wave", wave, m_wave);
        check("ready_after", midi_ready, 1'b1);
        $display("byte %02h: done=%0d tag=%0d wave_change=%0d vol=%02h wave=%0d",
                 b, done, tag, wc, parameters.volume, wave);
    endtask

    function automatic logic [7:0] rand_byte();
        int k;
        logic [6:0] ccs[8];
        ccs = '{7'd7, 7'd94, 7'd73, 7'd75, 7'd79, 7'd72, 7'd70, 7'd121};
        k = $urandom_range(0, 15);
        case (k)
            0, 1:  return 8'hB0;
            2:     return 8'hC0;
            3:     return {4'hB, 4'($urandom_range(0, 15))};
            4:     return {4'hC, 4'($urandom_range(0, 15))};
            5:     return 8'($urandom_range(8'h80, 8'hEF));
            6:     return 8'($urandom_range(8'hF0, 8'hF7));
            7:     return 8'($urandom_range(8'hF8, 8'hFF));
            8, 9, 10: return {1'b0, ccs[$urandom_range(0, 7)]};
            default: return 8'($urandom_range(0, 127));
        endcase
    endfunction

    task automatic send_seq(input logic [7:0] seq[$]);
        foreach (seq[i]) send(seq[i]);
    endtask

    initial begin
        rst        = 1'b1;
        midi_valid = 1'b0;
        midi_byte  = 8'h00;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_parameters", parameters, model_defaults());
        check("rst_wave", wave, 3'd0);
        check("rst_param_change", param_change, PARAM_NONE);
        check("rst_wave_change", wave_change, 1'b0);
        check("rst_ready", midi_ready, 1'b1);
        rst = 1'b0;

        send_seq('{8'hB0, 8'h07, 8'h55});
        send_seq('{8'hB0, 8'h49, 8'h10, 8'hF8, 8'h4B, 8'h20});
        send_seq('{8'hB3, 8'h07, 8'h11});
        send_seq('{8'hB0, 8'h07, 8'hC0, 8'h05});
        send_seq('{8'hB0, 8'h01, 8'h7F});
        send_seq('{8'hF0, 8'h07, 8'h22, 8'hF7, 8'h07, 8'h33});
        send_seq('{8'hB0, 8'h48, 8'h30, 8'hB0, 8'h79, 8'h00});
        send_seq('{8'hB0, 8'h07, 8'h07, 8'h07, 8'h07});

        // Asynchronous reset in the middle of a message.
        send_seq('{8'hB0, 8'h07});
        #2 rst = 1'b1;
        #1;
        check("arst_parameters", parameters, model_defaults());
        check("arst_wave", wave, 3'd0);
        check("arst_param_change", param_change, PARAM_NONE);
        check("arst_ready", midi_ready, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        send(8'h55);

        for (int i = 0; i < 400; i++) send(rand_byte());

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/midi_parameter_controller.md
Name: midi_parameter_controller

Overview:
- Parses a raw MIDI byte stream from the UART/MIDI receiver.
- Decodes Control Change (CC) and Program Change messages addressed to this synth.
- Holds the live PARAMETER::parameter_t register set and the current PARAMETER::wave_t, and emits a one-cycle PARAMETER::parameter_change_t tag on each update.
- Sits directly upstream of the voice/envelope/oscillator stages, which consume the parameter bus.

Parameters:
- LISTEN_CHANNEL, 4'd0, MIDI channel (0-15) accepted when OMNI=0.
- OMNI, 1'b0, 1 = accept channel-voice messages on any channel.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- midi_byte  in  8  received MIDI byte.
- midi_valid  in  1  midi_byte valid.
- midi_ready  out  1  byte accepted when midi_valid && midi_ready.
- parameters  out  $bits(parameter_t)  current parameter set, registered.
- wave  out  $bits(wave_t)  current waveform, registered.
- param_change  out  4  parameter_change_t; non-NONE for exactly one cycle per update.
- wave_change  out  1  one-cycle pulse when wave is written.

Behaviour:
- Reset (asynchronous, active-high):
  - parameters = DEFAULT_PARAMETERS; wave = SINE; param_change = PARAM_NONE; wave_change = 0.
  - FSM = IDLE; running status cleared; midi_ready = 1.
- Byte classes:
  - Status byte: bit7 = 1. Data byte: bit7 = 0.
  - Real-time bytes (0xF8-0xFF): accepted and discarded in every state; they cause no state or running-status change.
- FSM states: IDLE, DATA1, DATA2, APPLY, SKIP.
- IDLE (no running status):
  - Data bytes are dropped.
  - 0xBn (CC) matching channel -> DATA1, status latched.
  - 0xCn (Program Change) matching channel -> DATA1, status latched.
  - Any other channel-voice status (0x80-0xEF, or a non-matching channel) -> SKIP with running status cleared.
  - 0xF0-0xF7 -> SKIP with running status cleared.
- DATA1:
  - Data byte latched as d1. For CC -> DATA2; for Program Change -> APPLY.
  - A status byte restarts decoding exactly as in IDLE.
- DATA2:
  - Data byte latched as d2 -> APPLY.
  - A status byte restarts decoding as in IDLE; the partial message is discarded with no update.
- APPLY:
  - Lasts exactly one cycle; midi_ready = 0 only in this state.
  - Registers are written and param_change / wave_change are driven on the same edge, so outputs are visible the cycle after APPLY.
  - Latency: update visible 2 cycles after the final data-byte handshake.
  - Next state is DATA1 with the latched status kept (running status).
- SKIP:
  - Data bytes are dropped.
  - A status byte is decoded as in IDLE.
- CC map (d1 -> field, value = d2 written unmodified, 7 bits):
  - 7 -> volume / PARAM_VOLUME
  - 94 -> unison_detune / PARAM_UNISON_DETUNE
  - 73 -> attack_time / PARAM_ATTACK_TIME
  - 75 -> decay_time / PARAM_DECAY_TIME
  - 79 -> sustain_level / PARAM_SUSTAIN_LEVEL
  - 72 -> release_time / PARAM_RELEASE_TIME
  - 70 -> duty_cycle / PARAM_DUTY_CYCLE
  - Unmapped CC: no register write, param_change stays PARAM_NONE, APPLY still taken.
- Program Change: wave = d1[2:0]; wave_change = 1.
- Writing the same value as currently held still pulses param_change.
- Only one update per APPLY, so param_change and wave_change are never both active in the same cycle.

Optional Feature:
- Macro: MIDI_RESET_ALL_CONTROLLERS_EN.
- Defined: CC 121 (any d2) restores all parameters to DEFAULT_PARAMETERS in APPLY, and param_change = PARAM_RESET_ALL (enum value appended to parameter_change_t). wave is untouched.
- Undefined: CC 121 is treated as unmapped; the PARAM_RESET_ALL enum value is not declared.

Decomposition:
- The MIDI package gets:
  - STATUS_CC = 4'hB, STATUS_PROGRAM = 4'hC.
  - Real-time threshold 8'hF8.
  - The CC number constants for the map above.
- The PARAMETER package keeps parameter_t, DEFAULT_PARAMETERS, wave_t and parameter_change_t; PARAM_RESET_ALL is added under the macro.
- One sub-module: midi_byte_parser (FSM plus running status; outputs a message-valid strobe with status, d1, d2).
- The top level owns the CC map and the registers.

Test Plan:
- Reset: then check outputs → parameters == DEFAULT_PARAMETERS (volume 0x40, sustain 0x7F, duty 0x40); wave = SINE; param_change = PARAM_NONE.
- CC volume: bytes B0 07 55 → volume = 0x55; PARAM_VOLUME for exactly one cycle, 2 cycles after the 0x55 handshake; midi_ready low for one cycle.
- Running status plus real-time: B0 49 10, F8, 4B 20 → attack = 0x10 then decay = 0x20; two separate pulses; the F8 has no effect.
- Channel filter and interruption:
  - B3 07 11 with LISTEN_CHANNEL=0 → no change.
  - B0 07, then C0 05 → no volume change; wave = VIOLA; wave_change pulse.
- Unmapped CC and SysEx:
  - B0 01 7F → no change.
  - F0 07 22 F7 → no change.
  - A following 07 33 with no new status → dropped (running status cleared).
- Reset-all (macro on): B0 48 30, B0 79 00 → release 0x30 then back to 0x00; PARAM_RESET_ALL pulse. Async rst asserted mid-message (after B0 07) → the next 55 byte is dropped.
